// File: rtl/vco_adc_decim.sv
// vco_adc_decim: first-difference + integrate-and-dump (sinc1) decimator
// for a VCO-ADC edge counter, followed by a first-word-fall-through FIFO
// with a valid/ready read port and a sticky overflow flag.
module vco_adc_decim #(
    parameter int unsigned CW    = 8,
    parameter int unsigned OW    = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    input  logic                       en_i,
    input  logic [7:0]                 osr_i,
    input  logic [CW-1:0]              vco_cnt_i,
    output logic [OW-1:0]              sample_o,
    output logic                       sample_valid_o,
    input  logic                       sample_ready_i,
    output logic [$clog2(DEPTH):0]     fifo_level_o,
    output logic                       overflow_o,
    input  logic                       clr_ovf_i
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned SW = 8;

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state;
    logic [CW-1:0]   prev_cnt;
    logic [SW-1:0]   osr_q;
    logic [SW-1:0]   win_cnt;
    logic [OW-1:0]   acc;

    logic [OW-1:0]   mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;

    logic [CW-1:0]   diff_c;
    logic [OW:0]     sum_c;
    logic [OW-1:0]   sat_c;
    logic            push_c;
    logic            pop_c;
    logic            full_c;
    logic            drop_c;
    logic            wr_en_c;
    logic [LW-1:0]   level_nxt_c;
    logic [OW-1:0]   head_nxt_c;

    // Wrapped first difference, saturating accumulate and FIFO control decode
    always_comb begin
        diff_c      = vco_cnt_i - prev_cnt;
        sum_c       = {1'b0, acc} + (OW+1)'(diff_c);
        sat_c       = sum_c[OW] ? '1 : sum_c[OW-1:0];
        push_c      = (state == RUN) && en_i && (win_cnt == osr_q);
        pop_c       = sample_valid_o && sample_ready_i;
        full_c      = (fifo_level_o == LW'(DEPTH));
        drop_c      = push_c && full_c && !pop_c;
        wr_en_c     = push_c && !drop_c;
        level_nxt_c = fifo_level_o + LW'(wr_en_c) - LW'(pop_c);

        // Next head value: a push into an empty (or emptying) FIFO falls
        // straight through, otherwise a pop exposes the following entry.
        head_nxt_c = sample_o;
        if (fifo_level_o == '0) begin
            if (wr_en_c) head_nxt_c = sat_c;
        end else if (pop_c) begin
            if (fifo_level_o == LW'(1)) begin
                if (wr_en_c) head_nxt_c = sat_c;
            end else begin
                head_nxt_c = mem[rd_ptr + AW'(1)];
            end
        end
    end

    // Prime / run state machine with window counter and accumulator
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state    <= IDLE;
            prev_cnt <= '0;
            osr_q    <= '0;
            win_cnt  <= '0;
            acc      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en_i) begin
                        prev_cnt <= vco_cnt_i;
                        osr_q    <= osr_i;
                        acc      <= '0;
                        win_cnt  <= '0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (!en_i) begin
                        state <= IDLE;
                    end else begin
                        prev_cnt <= vco_cnt_i;
                        if (win_cnt == osr_q) begin
                            acc     <= '0;
                            win_cnt <= '0;
                            osr_q   <= osr_i;
                        end else begin
                            acc     <= sat_c;
                            win_cnt <= win_cnt + SW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // FIFO storage; contents need no reset since level gates visibility
    always_ff @(posedge wb_clk_i) begin
        if (wr_en_c) mem[wr_ptr] <= sat_c;
    end

    // FIFO pointers, level, registered head/valid and sticky overflow
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            fifo_level_o   <= '0;
            sample_valid_o <= 1'b0;
            sample_o       <= '0;
            overflow_o     <= 1'b0;
        end else begin
            if (wr_en_c) wr_ptr <= wr_ptr + AW'(1);
            if (pop_c)   rd_ptr <= rd_ptr + AW'(1);
            fifo_level_o   <= level_nxt_c;
            sample_valid_o <= (level_nxt_c != '0);
            sample_o       <= head_nxt_c;
            if (drop_c)
                overflow_o <= 1'b1;
            else if (clr_ovf_i)
                overflow_o <= 1'b0;
        end
    end

endmodule

// File: doc/vco_adc_decim.md
# vco_adc_decim

Decimation and buffering stage directly downstream of the VCO-ADC counter in the user project. Each clock it takes the free-running VCO edge count, forms the wrapped first difference, and integrates-and-dumps over a programmable window (sinc¹ decimation). Finished samples go into a small first-word-fall-through FIFO, and the FIFO is read through a valid/ready port by the Wishbone/logic-analyzer readout.

## Interface
- `CW`, 8: width of the VCO count input.
- `OW`, 16: width of output samples.
- `DEPTH`, 8: FIFO depth in entries. Must be a power of two, ≥2.
- `wb_clk_i`, in, 1: the only clock; all logic is on its rising edge.
- `wb_rst_i`, in, 1: reset, asynchronous, active-high.
- `en_i`, in, 1: conversion enable.
- `osr_i`, in, 8: window length minus one. N = `osr_i` + 1, range 1..256.
- `vco_cnt_i`, in, CW: free-running VCO edge count, already synchronous to `wb_clk_i`.
- `sample_o`, out, OW: FIFO head sample.
- `sample_valid_o`, out, 1: FIFO not empty.
- `sample_ready_i`, in, 1: consumer accepts the head sample.
- `fifo_level_o`, out, log2(DEPTH)+1: number of occupied entries.
- `overflow_o`, out, 1: sticky flag; a sample was dropped.
- `clr_ovf_i`, in, 1: clears `overflow_o`.

## Operation
- **Reset values.** All outputs are 0. Internal state is also cleared: `prev_cnt`, `acc`, window counter, FIFO pointers, and state = IDLE.
- **State machine.**
  - IDLE: when `en_i`=1, capture `prev_cnt` ← `vco_cnt_i`, latch `osr_q` ← `osr_i`, clear `acc` and the window counter, then go to RUN. This is the priming cycle; nothing is accumulated.
  - RUN: each cycle compute `diff` = (`vco_cnt_i` − `prev_cnt`) mod 2^CW, then update `prev_cnt` ← `vco_cnt_i` and the window counter += 1.
  - RUN, when the window counter equals `osr_q` (the Nth diff):
    - Push sat(`acc` + `diff`) to the FIFO.
    - Clear `acc` and the window counter.
    - Re-latch `osr_q` ← `osr_i`.
  - RUN, otherwise: `acc` ← sat(`acc` + `diff`).
  - RUN, when `en_i`=0: go to IDLE. The partial window is discarded; FIFO contents are retained.
- **Arithmetic.** `diff` is unsigned CW bits, so counter wrap is handled by the modulo subtraction. The accumulator is OW bits and saturates at 2^OW−1. With the defaults it never saturates (256·255 < 2^16).
- **`osr_i` changes** take effect only at a window boundary or when priming.
- **FIFO behaviour.**
  - First-word-fall-through: `sample_o` shows the head entry whenever `sample_valid_o`=1.
  - Pop occurs when `sample_valid_o` && `sample_ready_i`.
  - `sample_o` is don't-care when the FIFO is empty.
- **Push when full, no pop in the same cycle:** the new sample is dropped, `overflow_o` is set, and stored contents are unchanged.
- **Push and pop in the same cycle:** both take effect, including when full. The level is unchanged and there is no overflow.
- **Overflow flag.** `clr_ovf_i`=1 clears `overflow_o`. If a clear and a drop happen in the same cycle, set wins.
- **Reset mid-operation:** the FIFO is emptied and any partial window is lost.

## Timing
- **Cycle numbering.** E0 is the first rising edge with `en_i`=1 (priming). Diffs are taken at edges E1..EN.
- **Sample latency.** The push happens at EN. `sample_valid_o` and `fifo_level_o` reflect the new entry right after EN.
- **N=1:** one sample per cycle, starting after E1.
- **Throughput:** one sample per N cycles.
- **Pop timing.** A pop at edge E updates `sample_o`, `sample_valid_o`, and `fifo_level_o` right after E. There is no combinational path from `sample_ready_i` to `sample_o`.
- **Flag timing.** `overflow_o` rises right after the edge at which the drop occurs.
- **Re-enable.** A re-enable after `en_i` was low always spends one priming edge before any diff is taken.

## Test plan
1. **Basic window.** `vco_cnt_i` steps +3 per cycle, `osr_i`=3, `sample_ready_i`=1 → a sample of 12 every 4 cycles. The first `sample_valid_o` appears after E4.
2. **Counter wrap.** CW=8, count starts at 250 and steps +10, `osr_i`=3 → every sample is 40, including the windows that cross 255→0.
3. **Overflow.**
   - Setup: `sample_ready_i`=0, `osr_i`=0, step +1.
   - After 8 samples: `fifo_level_o`=8.
   - On the 9th sample: `overflow_o`=1 and the level stays 8.
   - Then set ready=1: eight samples of value 1 drain.
   - Then pulse `clr_ovf_i`: `overflow_o`=0.
4. **Push and pop at full.** With the FIFO full, `sample_ready_i`=1 and a push in the same cycle → level stays 8, `overflow_o` stays 0, and order is preserved.
5. **Disable and OSR change.**
   - Drop `en_i` after 2 of 4 diffs → no sample is produced; on re-enable the next sample is a full window of 4 diffs.
   - Change `osr_i` 3→1 mid-window → the current window stays 4 cycles and the next window is 2.
6. **Reset mid-run.** Assert `wb_rst_i` asynchronously with 5 entries queued → all outputs are 0 immediately. After release, the FIFO is empty and the block primes again.
